// File: rtl/rv32_mod_lsu_controller.sv
// rv32_mod_lsu_controller: load/store sequencer between the core's LSU controls
// and a single-outstanding req/ack data bus. Checks alignment, builds byte
// enables and lane-replicated store data, and aligns/extends load data.
// Optional bus-response timeout is compiled in with `define RV32_LSU_TIMEOUT_EN.
module rv32_mod_lsu_controller #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        lsu_valid,
  input  logic [3:0]  ram_req,
  input  logic        ram_wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        fault_align,
  output logic        fault_bus,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic        bus_err,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t      state, state_nx;
  logic [2:0]  f3;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        legal;
  logic        timeout_hit;
  logic        unused_bits;

  assign f3 = ram_req[2:0];
  // Bit 3 of the width code carries no meaning for this unit.
  assign unused_bits = ram_req[3];

  // Legal width/sign code for the access direction and the address offset.
  function automatic logic access_legal(input logic [2:0] code, input logic wr,
                                        input logic [1:0] off);
    case (code)
      3'b000:  access_legal = 1'b1;
      3'b001:  access_legal = ~off[0];
      3'b010:  access_legal = (off == 2'b00);
      3'b100:  access_legal = ~wr;
      3'b101:  access_legal = ~wr & ~off[0];
      default: access_legal = 1'b0;
    endcase
  endfunction

  // Byte enables for the addressed lanes.
  function automatic logic [3:0] be_gen(input logic [2:0] code, input logic [1:0] off);
    case (code[1:0])
      2'b00:   be_gen = 4'b0001 << off;
      2'b01:   be_gen = 4'b0011 << off;
      default: be_gen = 4'b1111;
    endcase
  endfunction

  // Store data replicated across all lanes so any byte enable picks the right bits.
  function automatic logic [31:0] wdata_rep(input logic [2:0] code, input logic [31:0] d);
    case (code[1:0])
      2'b00:   wdata_rep = {4{d[7:0]}};
      2'b01:   wdata_rep = {2{d[15:0]}};
      default: wdata_rep = d;
    endcase
  endfunction

  // Shift the addressed lane down and sign- or zero-extend it.
  function automatic logic [31:0] load_align(input logic [2:0] code, input logic [1:0] off,
                                             input logic [31:0] d);
    logic [31:0] sh;
    sh = d >> {off, 3'b000};
    case (code)
      3'b000:  load_align = {{24{sh[7]}}, sh[7:0]};
      3'b001:  load_align = {{16{sh[15]}}, sh[15:0]};
      3'b100:  load_align = {24'h0, sh[7:0]};
      3'b101:  load_align = {16'h0, sh[15:0]};
      default: load_align = sh;
    endcase
  endfunction

  assign legal = access_legal(f3, ram_wr, addr[1:0]);

`ifdef RV32_LSU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt;

  // Count cycles spent waiting for a bus response; cleared outside BUS.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)              cnt <= '0;
    else if (state == BUS)  cnt <= cnt + 1'b1;
    else                    cnt <= '0;
  end

  assign timeout_hit = (state == BUS) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES[0];
  assign timeout_hit    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic: RESP always lasts exactly one cycle.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (lsu_valid) state_nx = legal ? BUS : RESP;
      BUS:  if (bus_err || bus_ack || timeout_hit) state_nx = RESP;
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign stall = ((state == IDLE) && lsu_valid) || (state == BUS);
  assign done  = (state == RESP);

  // Launch the bus transaction, hold it during BUS, capture the response.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_be      <= '0;
      bus_wdata   <= '0;
      rdata       <= '0;
      fault_align <= 1'b0;
      fault_bus   <= 1'b0;
      f3_q        <= '0;
      off_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (lsu_valid) begin
            if (legal) begin
              bus_req   <= 1'b1;
              bus_we    <= ram_wr;
              bus_addr  <= {addr[31:2], 2'b00};
              bus_be    <= be_gen(f3, addr[1:0]);
              bus_wdata <= wdata_rep(f3, wdata);
              f3_q      <= f3;
              off_q     <= addr[1:0];
            end else begin
              fault_align <= 1'b1;
              rdata       <= '0;
            end
          end
        end
        BUS: begin
          if (bus_err || timeout_hit) begin
            bus_req   <= 1'b0;
            fault_bus <= 1'b1;
            rdata     <= '0;
          end else if (bus_ack) begin
            bus_req <= 1'b0;
            rdata   <= bus_we ? 32'h0 : load_align(f3_q, off_q, bus_rdata);
          end
        end
        RESP: begin
          fault_align <= 1'b0;
          fault_bus   <= 1'b0;
          rdata       <= '0;
        end
        default: bus_req <= 1'b0;
      endcase
    end
  end

endmodule
